// File: rtl/int_sequencer.sv
// Interrupt/reset sequencer: NMI edge capture, IRQ merge, power-on delay and
// RESET > NMI > IRQ > BRK arbitration with a hold-until-ack request handshake.
module int_sequencer #(
  parameter int          N_IRQ      = 4,
  parameter int          RST_CYCLES = 6,
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] RST_VEC    = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE,
  localparam int         SRC_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             phi1,
  input  logic             rst,
  input  logic             nmi_n,
  input  logic [N_IRQ-1:0] irq_n,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             i_flag,
  input  logic             sync,
  input  logic             rdy,
  input  logic             brk_op,
  input  logic             int_ack,
  output logic             int_req,
  output logic [1:0]       int_type,
  output logic [15:0]      vec_addr,
  output logic [SRC_W-1:0] irq_src,
  output logic             rst_busy
);

  // state      | meaning
  // ST_RST_DLY | power-on/reset delay running, no arbitration
  // ST_IDLE    | waiting for a qualifying sync & rdy boundary
  // ST_REQ     | request presented to the CPU FSM, held until int_ack

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

  localparam logic [1:0] T_RESET = 2'd0;
  localparam logic [1:0] T_NMI   = 2'd1;
  localparam logic [1:0] T_IRQ   = 2'd2;
  localparam logic [1:0] T_BRK   = 2'd3;

  typedef enum logic [1:0] {ST_RST_DLY, ST_IDLE, ST_REQ} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic              nmi_prev_q, nmi_prev_d;
  logic              nmi_pend_q, nmi_pend_d;
  logic [1:0]        int_type_q, int_type_d;
  logic [SRC_W-1:0]  irq_src_q, irq_src_d;

  logic              nmi_edge;
  logic              req_ack;
  logic              arb_en;
  logic              hijack;
  logic [N_IRQ-1:0]  irq_act;
  logic              irq_any;
  logic [SRC_W-1:0]  src_win;

  always_ff @(posedge phi1 or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RST_DLY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST_DLY: if (rst_cnt_q == CNT_LAST) state_d = ST_REQ;
      ST_IDLE:    if (arb_en && (nmi_pend_q || irq_any || brk_op)) state_d = ST_REQ;
      ST_REQ:     if (int_ack) state_d = ST_IDLE;
      default:    state_d = ST_RST_DLY;
    endcase
  end

  always_comb begin
    int_req  = (state_q == ST_REQ);
    rst_busy = (state_q == ST_RST_DLY);
    int_type = int_type_q;
    irq_src  = irq_src_q;
    case (int_type_q)
      T_RESET: vec_addr = RST_VEC;
      T_NMI:   vec_addr = NMI_VEC;
      default: vec_addr = IRQ_VEC;
    endcase
  end

  always_comb begin
    irq_act = ~irq_n & ~irq_mask;
    irq_any = (|irq_act) & ~i_flag;
    src_win = '0;
    // Descending scan so the lowest active index is the final assignment.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (irq_act[i]) src_win = SRC_W'(i);
    end
  end

  always_comb begin
    nmi_edge = nmi_prev_q & ~nmi_n;
    req_ack  = (state_q == ST_REQ) && int_ack;
    arb_en   = (state_q == ST_IDLE) && sync && rdy;
    hijack   = (state_q == ST_REQ) && !int_ack && rdy && nmi_pend_q && int_type_q[1];

    nmi_prev_d = nmi_n;
    nmi_pend_d = nmi_pend_q;
    if (nmi_edge) begin
      nmi_pend_d = 1'b1;
    end else if (req_ack && int_type_q == T_NMI) begin
      nmi_pend_d = 1'b0;
    end

    rst_cnt_d = rst_cnt_q;
    if (state_q == ST_RST_DLY && rst_cnt_q != CNT_LAST) rst_cnt_d = rst_cnt_q + 1'b1;

    int_type_d = int_type_q;
    irq_src_d  = irq_src_q;
    if (state_q == ST_RST_DLY) begin
      int_type_d = T_RESET;
    end else if (arb_en) begin
      if (nmi_pend_q) begin
        int_type_d = T_NMI;
      end else if (irq_any) begin
        int_type_d = T_IRQ;
        irq_src_d  = src_win;
      end else if (brk_op) begin
        int_type_d = T_BRK;
      end
    end else if (hijack) begin
      int_type_d = T_NMI;
    end
  end

  always_ff @(posedge phi1 or negedge rst) begin
    if (!rst) begin
      rst_cnt_q  <= '0;
      nmi_prev_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      int_type_q <= T_RESET;
      irq_src_q  <= '0;
    end else begin
      rst_cnt_q  <= rst_cnt_d;
      nmi_prev_q <= nmi_prev_d;
      nmi_pend_q <= nmi_pend_d;
      int_type_q <= int_type_d;
      irq_src_q  <= irq_src_d;
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer with hand-computed expectations.
module tb_int_sequencer;

  logic        phi1 = 1'b0;
  logic        rst;
  logic        nmi_n;
  logic [3:0]  irq_n;
  logic [3:0]  irq_mask;
  logic        i_flag;
  logic        sync;
  logic        rdy;
  logic        brk_op;
  logic        int_ack;
  logic        int_req;
  logic [1:0]  int_type;
  logic [15:0] vec_addr;
  logic [1:0]  irq_src;
  logic        rst_busy;

  int n_chk  = 0;
  int n_fail = 0;
  int nmi_cnt;

  int_sequencer dut (
    .phi1     (phi1),
    .rst      (rst),
    .nmi_n    (nmi_n),
    .irq_n    (irq_n),
    .irq_mask (irq_mask),
    .i_flag   (i_flag),
    .sync     (sync),
    .rdy      (rdy),
    .brk_op   (brk_op),
    .int_ack  (int_ack),
    .int_req  (int_req),
    .int_type (int_type),
    .vec_addr (vec_addr),
    .irq_src  (irq_src),
    .rst_busy (rst_busy)
  );

  always #5 phi1 = ~phi1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge phi1);
    #1;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("ack_clears_req", 32'(int_req), 0);
  endtask

  initial begin
    rst = 1'b0; nmi_n = 1'b1; irq_n = 4'hF; irq_mask = 4'h0; i_flag = 1'b1;
    sync = 1'b0; rdy = 1'b1; brk_op = 1'b0; int_ack = 1'b0;
    #3;
    chk("rst_req",   32'(int_req),  0);
    chk("rst_type",  32'(int_type), 0);
    chk("rst_vec",   32'(vec_addr), 32'hFFFC);
    chk("rst_src",   32'(irq_src),  0);
    chk("rst_busy",  32'(rst_busy), 1);

    // reset release: request exactly 6 edges later
    rst = 1'b1;
    repeat (5) step();
    chk("dly_busy5", 32'(rst_busy), 1);
    chk("dly_req5",  32'(int_req),  0);
    step();
    chk("dly_busy6", 32'(rst_busy), 0);
    chk("dly_req6",  32'(int_req),  1);
    chk("dly_type6", 32'(int_type), 0);
    chk("dly_vec6",  32'(vec_addr), 32'hFFFC);
    do_ack();

    // NMI wins over IRQ source 2, then IRQ follows
    irq_n = 4'b1011; i_flag = 1'b0; nmi_n = 1'b0;
    step();
    chk("nmi_nosync", 32'(int_req), 0);
    sync = 1'b1;
    step();
    chk("nmi_req",  32'(int_req),  1);
    chk("nmi_type", 32'(int_type), 1);
    chk("nmi_vec",  32'(vec_addr), 32'hFFFA);
    do_ack();
    step();
    chk("irq_req",  32'(int_req),  1);
    chk("irq_type", 32'(int_type), 2);
    chk("irq_src",  32'(irq_src),  2);
    chk("irq_vec",  32'(vec_addr), 32'hFFFE);
    do_ack();
    sync = 1'b0; nmi_n = 1'b1; irq_n = 4'hF;
    step();

    // masking, I flag and BRK
    irq_n = 4'b0000; irq_mask = 4'b0011; sync = 1'b1;
    step();
    chk("mask_type", 32'(int_type), 2);
    chk("mask_src",  32'(irq_src),  2);
    do_ack();
    i_flag = 1'b1;
    step();
    chk("iflag_noreq", 32'(int_req), 0);
    brk_op = 1'b1;
    step();
    chk("brk_req",  32'(int_req),  1);
    chk("brk_type", 32'(int_type), 3);
    chk("brk_vec",  32'(vec_addr), 32'hFFFE);
    chk("brk_src",  32'(irq_src),  2);
    do_ack();
    sync = 1'b0; brk_op = 1'b0; irq_n = 4'hF; irq_mask = 4'h0; i_flag = 1'b0;
    step();

    // hijack of a pending IRQ by a late NMI edge
    irq_n = 4'b1110; sync = 1'b1;
    step();
    chk("hj_irq_type", 32'(int_type), 2);
    chk("hj_irq_src",  32'(irq_src),  0);
    sync = 1'b0; nmi_n = 1'b0;
    step();
    chk("hj_pre_type", 32'(int_type), 2);
    step();
    chk("hj_req",  32'(int_req),  1);
    chk("hj_type", 32'(int_type), 1);
    chk("hj_vec",  32'(vec_addr), 32'hFFFA);
    do_ack();
    irq_n = 4'hF; sync = 1'b1;
    step();
    chk("hj_no_second", 32'(int_req), 0);
    sync = 1'b0; nmi_n = 1'b1;
    step();

    // held-low NMI yields exactly one request
    nmi_cnt = 0;
    nmi_n = 1'b0; sync = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (int_req && int_type == 2'd1 && !int_ack) begin
        nmi_cnt++;
        int_ack = 1'b1;
      end else begin
        int_ack = 1'b0;
      end
    end
    int_ack = 1'b0;
    chk("held_nmi_count", 32'(nmi_cnt), 1);
    nmi_n = 1'b1; sync = 1'b0;
    step();

    // new NMI edge in the ack cycle survives the clear
    nmi_n = 1'b0; sync = 1'b1;
    step();
    step();
    chk("edge_ack_req1", 32'(int_type), 1);
    nmi_n = 1'b1;
    step();
    nmi_n = 1'b0; int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("edge_ack_drop", 32'(int_req), 0);
    step();
    chk("edge_ack_req2",  32'(int_req),  1);
    chk("edge_ack_type2", 32'(int_type), 1);
    do_ack();
    sync = 1'b0; nmi_n = 1'b1;
    step();

    // reset asserted while an IRQ request is pending
    irq_n = 4'b1101; sync = 1'b1;
    step();
    chk("mid_irq_src", 32'(irq_src), 1);
    sync = 1'b0; irq_n = 4'hF;
    #2 rst = 1'b0;
    #1;
    chk("mid_req",  32'(int_req),  0);
    chk("mid_busy", 32'(rst_busy), 1);
    chk("mid_vec",  32'(vec_addr), 32'hFFFC);
    chk("mid_src",  32'(irq_src),  0);
    rst = 1'b1;
    repeat (5) step();
    chk("mid_dly_req5", 32'(int_req), 0);
    step();
    chk("mid_dly_req6", 32'(int_req), 1);
    do_ack();

    // rdy freezes arbitration but not NMI capture
    nmi_n = 1'b0; rdy = 1'b0; sync = 1'b1;
    step();
    step();
    chk("rdy0_noreq", 32'(int_req), 0);
    rdy = 1'b1;
    step();
    chk("rdy1_req",  32'(int_req),  1);
    chk("rdy1_type", 32'(int_type), 1);
    do_ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
